hex_event_counter: RTL and testbench

//   Debounced push-button event counter feeding the six seven_segment decoders on the DE10-Standard.

---
 rtl/hex_event_counter.sv | 164 ++++++++++++++++
 tb/tb_hex_event_counter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_event_counter.sv
// Debounced push-button event counter: 6-digit BCD up/down with 2-digit preset load.
// Optional feature macro HEX_LZB_EN enables leading-zero blanking on o_blank.
module hex_event_counter #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_btn_n,
   input  logic       i_dir,
   input  logic       i_load,
   input  logic [7:0] i_load_val,
   output logic [3:0] o_digit0,
   output logic [3:0] o_digit1,
   output logic [3:0] o_digit2,
   output logic [3:0] o_digit3,
   output logic [3:0] o_digit4,
   output logic [3:0] o_digit5,
   output logic [5:0] o_blank,
   output logic       o_wrap
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_btn_sync;
   logic [SYNC_STAGES-1:0] r_load_sync;
   logic                   r_load_prev;
   logic                   r_stable;
   logic                   r_stable_d;
   logic                   r_step;
   logic [CW-1:0]          r_db_cnt;
   logic [3:0]             r_dig [6];
   logic                   r_wrap;

   logic [3:0]             w_dig_nx [6];
   logic                   w_wrap_nx;
   logic                   w_btn_s;
   logic                   w_load_s;
   logic                   w_load_rise;

   assign w_btn_s     = r_btn_sync[SYNC_STAGES-1];
   assign w_load_s    = r_load_sync[SYNC_STAGES-1];
   assign w_load_rise = w_load_s & ~r_load_prev;

   function automatic logic [3:0] clamp9(input logic [3:0] v);
      return (v > 4'd9) ? 4'd9 : v;
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_btn_sync  <= '1;
         r_load_sync <= '0;
         r_load_prev <= 1'b0;
      end else begin
         r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0], i_btn_n};
         r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], i_load};
         r_load_prev <= w_load_s;
      end
   end

   // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stable   <= 1'b1;
         r_stable_d <= 1'b1;
         r_step     <= 1'b0;
         r_db_cnt   <= '0;
      end else begin
         r_stable_d <= r_stable;
         r_step     <= r_stable_d & ~r_stable;
         if (w_btn_s == r_stable) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == CNT_MAX) begin
            r_stable <= w_btn_s;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      logic carry;
      carry     = 1'b1;
      w_dig_nx  = r_dig;
      w_wrap_nx = 1'b0;
      if (w_load_rise) begin
         w_dig_nx[0] = clamp9(i_load_val[3:0]);
         w_dig_nx[1] = clamp9(i_load_val[7:4]);
         for (int i = 2; i < 6; i++) begin
            w_dig_nx[i] = 4'd0;
         end
      end else if (r_step) begin
         for (int i = 0; i < 6; i++) begin
            if (carry) begin
               if (!i_dir) begin
                  if (r_dig[i] == 4'd9) begin
                     w_dig_nx[i] = 4'd0;
                  end else begin
                     w_dig_nx[i] = r_dig[i] + 4'd1;
                     carry       = 1'b0;
                  end
               end else begin
                  if (r_dig[i] == 4'd0) begin
                     w_dig_nx[i] = 4'd9;
                  end else begin
                     w_dig_nx[i] = r_dig[i] - 4'd1;
                     carry       = 1'b0;
                  end
               end
            end
         end
         w_wrap_nx = carry;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_dig  <= '{default: 4'd0};
         r_wrap <= 1'b0;
      end else begin
         r_dig  <= w_dig_nx;
         r_wrap <= w_wrap_nx;
      end
   end

`ifdef HEX_LZB_EN
   logic [5:0] r_blank;
   logic [5:0] w_blank_nx;

   // Computed from next-state digits so blank moves with the digits.
   always_comb begin
      logic zero;
      zero       = 1'b1;
      w_blank_nx = '0;
      for (int i = 5; i >= 1; i--) begin
         zero          = zero & (w_dig_nx[i] == 4'd0);
         w_blank_nx[i] = zero;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_blank <= 6'b111110;
      end else begin
         r_blank <= w_blank_nx;
      end
   end

   assign o_blank = r_blank;
`else
   assign o_blank = 6'b000000;
`endif

   assign o_digit0 = r_dig[0];
   assign o_digit1 = r_dig[1];
   assign o_digit2 = r_dig[2];
   assign o_digit3 = r_dig[3];
   assign o_digit4 = r_dig[4];
   assign o_digit5 = r_dig[5];
   assign o_wrap   = r_wrap;

endmodule

// File: tb/tb_hex_event_counter.sv
// Scoreboard bench for hex_event_counter: an integer-count model predicts every output change.
// Build with HEX_LZB_EN defined or not; expected blanking follows the same macro.
module tb_hex_event_counter;

   localparam int D = 4;
   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_n = 1'b1;
   logic       dir = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_val = 8'h00;
   logic [3:0] d0, d1, d2, d3, d4, d5;
   logic [5:0] blank;
   logic       wrap;

   hex_event_counter #(
      .DEBOUNCE_CYCLES(D),
      .SYNC_STAGES(S)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_btn_n(btn_n),
      .i_dir(dir),
      .i_load(load),
      .i_load_val(load_val),
      .o_digit0(d0),
      .o_digit1(d1),
      .o_digit2(d2),
      .o_digit3(d3),
      .o_digit4(d4),
      .o_digit5(d5),
      .o_blank(blank),
      .o_wrap(wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int cnt;
      bit wrap;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic logic [23:0] to_bcd(input int c);
      logic [23:0] r;
      int v;
      v = c;
      r = '0;
      for (int i = 0; i < 6; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [5:0] exp_blank(input int c);
      logic [5:0] b;
      int pw;
      b  = '0;
      pw = 1;
`ifdef HEX_LZB_EN
      for (int i = 1; i < 6; i++) begin
         pw   = pw * 10;
         b[i] = (c < pw);
      end
`endif
      return b;
   endfunction

   // Reference model: count as an integer, timing from sample history.
   int m_cyc = 0;
   int m_cnt = 0;
   bit m_wrap = 0;
   bit m_stable = 1;
   int m_run = 0;
   bit m_bh [S];
   bit m_lh [S];
   bit m_lprev = 0;
   bit m_p1 = 0;
   bit m_p2 = 0;

   always @(posedge clk) begin
      bit bs, ls, stepnow, lrise;
      int ncnt;
      bit nwrap;
      m_cyc++;
      ncnt  = m_cnt;
      nwrap = 0;
      if (rst) begin
         ncnt     = 0;
         m_stable = 1;
         m_run    = 0;
         for (int i = 0; i < S; i++) begin
            m_bh[i] = 1;
            m_lh[i] = 0;
         end
         m_lprev = 0;
         m_p1    = 0;
         m_p2    = 0;
      end else begin
         bs = m_bh[S-1];
         ls = m_lh[S-1];
         for (int i = S - 1; i > 0; i--) begin
            m_bh[i] = m_bh[i-1];
            m_lh[i] = m_lh[i-1];
         end
         m_bh[0] = btn_n;
         m_lh[0] = load;
         stepnow = m_p2;
         m_p2    = m_p1;
         m_p1    = 0;
         if (bs == m_stable) begin
            m_run = 0;
         end else begin
            m_run++;
            if (m_run == D) begin
               m_stable = bs;
               m_run    = 0;
               if (!bs) m_p1 = 1;
            end
         end
         lrise   = ls & ~m_lprev;
         m_lprev = ls;
         if (lrise) begin
            ncnt = ((load_val[7:4] > 9) ? 9 : int'(load_val[7:4])) * 10
                 + ((load_val[3:0] > 9) ? 9 : int'(load_val[3:0]));
         end else if (stepnow) begin
            if (!dir) begin
               nwrap = (m_cnt == 999999);
               ncnt  = (m_cnt + 1) % 1000000;
            end else begin
               nwrap = (m_cnt == 0);
               ncnt  = (m_cnt == 0) ? 999999 : m_cnt - 1;
            end
         end
      end
      if (ncnt != m_cnt || nwrap != m_wrap) begin
         q.push_back('{cyc: m_cyc, cnt: ncnt, wrap: nwrap});
      end
      m_cnt  = ncnt;
      m_wrap = nwrap;
   end

   // Monitor: every change of DUT outputs consumes one scoreboard entry.
   bit          mon_en = 0;
   logic [30:0] mon_last;

   always @(negedge clk) begin
      logic [30:0] cur;
      exp_t e;
      if (mon_en) begin
         cur = {d5, d4, d3, d2, d1, d0, wrap, blank};
         if (cur !== mon_last) begin
            mon_last = cur;
            n_chk++;
            if (q.size() == 0) begin
               $display("FAIL unexpected_change cyc=%0d: got digits=%h wrap=%b blank=%b, none expected",
                        m_cyc, cur[30:7], wrap, blank);
            end else begin
               e = q.pop_front();
               if (cur[30:7] === to_bcd(e.cnt) && wrap === e.wrap &&
                   blank === exp_blank(e.cnt) && m_cyc == e.cyc) begin
                  n_pass++;
               end else begin
                  $display("FAIL event cyc=%0d: got digits=%h wrap=%b blank=%b, want digits=%h wrap=%b blank=%b at cyc=%0d",
                           m_cyc, cur[30:7], wrap, blank, to_bcd(e.cnt), e.wrap,
                           exp_blank(e.cnt), e.cyc);
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int lo, input int hi);
      btn_n = 1'b0;
      tick(lo);
      btn_n = 1'b1;
      tick(hi);
   endtask

   task automatic chk_reset(input string name, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h, want %h", name, got, want);
   endtask

   initial begin
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      chk_reset("reset_digits", 32'({d5, d4, d3, d2, d1, d0}), 32'h0);
      chk_reset("reset_wrap", 32'(wrap), 32'h0);
`ifdef HEX_LZB_EN
      chk_reset("reset_blank", 32'(blank), 32'h3E);
`else
      chk_reset("reset_blank", 32'(blank), 32'h00);
`endif
      mon_last = {d5, d4, d3, d2, d1, d0, wrap, blank};
      mon_en   = 1;

      dir = 1'b0;
      press(20, 15);
      press(3, 15);

      // Load rises so that it lands on the same edge as a step.
      load_val = 8'h5C;
      btn_n    = 1'b0;
      tick(5);
      load = 1'b1;
      tick(20);
      btn_n = 1'b1;
      tick(15);
      load = 1'b0;
      tick(5);

      load_val = 8'h00;
      load     = 1'b1;
      tick(6);
      load = 1'b0;
      tick(4);
      dir = 1'b1;
      press(20, 15);
      dir = 1'b0;
      press(20, 15);
      dir = 1'b1;
      press(20, 15);

      // Reset in the middle of a debounce window, button still held.
      dir   = 1'b0;
      btn_n = 1'b0;
      tick(4);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(25);
      btn_n = 1'b1;
      tick(15);

      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 7) == 0) begin
            load_val = 8'($urandom);
            load     = 1'b1;
            tick($urandom_range(1, 5));
            load = 1'b0;
            tick($urandom_range(1, 5));
         end else begin
            dir = 1'($urandom);
            press($urandom_range(1, 12), $urandom_range(1, 10));
         end
      end
      btn_n = 1'b1;
      tick(20);

      n_chk++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d pending events, want 0", q.size());

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
